pong_game_renderer: RTL
=======================

// Module: pong_game_renderer
// PURPOSE
//  Pixel-stage consumer of the VGA sync/counter generator. Takes counter_x/counter_y/in_display_area, runs a
//  two-player Pong game updated once per frame, and drives registered 1-bit RGB for the current pixel.
//  Sits between the sync generator and the board VGA pins; the sync outputs bypass this block.
// PARAMETERS
//  PADDLE_H      64  paddle height, pixels (paddle width fixed at 8)
//  PADDLE_SPEED  4   paddle step per frame, pixels
//  BALL_SPEED    2   ball step per frame per axis, pixels (ball is 8x8)
//  WIN_SCORE     9   score that ends the game (<=15)
//  SERVE_FRAMES  60  frames the ball is held centred after reset or a point
// PORTS
//  clk              in   1   pixel clock, same clock as the sync generator
//  rst_n            in   1   asynchronous active-low reset
//  counter_x        in   10  current pixel column
//  counter_y        in   9   current pixel row (truncated counter; 480 occurs once per frame)
//  in_display_area  in   1   high for visible pixels (0..639, 0..479)
//  l_up, l_dn       in   1   left paddle buttons, synchronous, sampled on frame tick
//  r_up, r_dn       in   1   right paddle buttons, as above
//  start            in   1   restart from GAMEOVER, sampled on frame tick
//  vga_r/g/b        out  1   pixel colour, registered
//  score_l, score_r out  4   player scores
//  game_over        out  1   high in GAMEOVER
// BEHAVIOUR
//  Reset: vga_r/g/b=0, scores=0, game_over=0, state=SERVE, serve counter=SERVE_FRAMES, ball=(316,236),
//   dx=+1, dy=+1, both paddle y=(480-PADDLE_H)/2. Reset mid-frame takes effect immediately; no partial frame kept.
//  frame_tick: one-clk pulse when counter_x==0 && counter_y==480; all game state updates on that edge only.
//  Paddles (every tick, every state except GAMEOVER): up XOR dn moves y by -/+PADDLE_SPEED; both/neither: hold.
//   Clamp to [0, 480-PADDLE_H]; no wrap/underflow. Left paddle x=16..23, right x=616..623.
//  FSM (ticks only):
//   SERVE: ball held at centre; count down; at 0 -> PLAY.
//   PLAY: ball += dx*BALL_SPEED, dy*BALL_SPEED; evaluate collisions on the new position, same tick:
//    top y<=0 -> y=0, dy=+1; bottom y>=472 -> y=472, dy=-1.
//    left paddle: dx=-1, x<=24, ball y-range overlaps paddle -> x=24, dx=+1. Right: dx=+1, x>=608, overlap -> x=608, dx=-1.
//    miss: x<=0 (left) -> score_r++; x>=632 (right) -> score_l++; go SERVE, recentre ball,
//     dx toward player who conceded, dy unchanged, reload counter. Paddle hit takes priority over miss
//     on the same tick; a wall bounce and a paddle hit on the same tick both apply.
//    score reaching WIN_SCORE -> GAMEOVER instead of SERVE; score saturates, never wraps.
//   GAMEOVER: game_over=1, ball hidden, paddles frozen; start=1 -> scores=0, game_over=0, SERVE.
//  Arithmetic: ball x 10b, y 9b signed intermediate (11b) so underflow clamps instead of wrapping.
//  Render, 1-clk latency from counters: colour registered from current counter_x/counter_y.
//   in_display_area=0 -> black. Priority: ball (white, hidden in GAMEOVER) > paddles (white)
//   > net (green, x 319..320, counter_y[4]==0) > black.
// CONFIGURATION
//  PONG_AI_EN defined: r_up/r_dn ignored; right paddle centre tracks ball centre at PADDLE_SPEED,
//   dead band +-4 px, same clamp. Undefined: right paddle driven by r_up/r_dn. Port list identical.
// TESTING
//  reset low mid-frame -> all outputs 0, ball at (316,236) after release; no RGB until next visible pixel.
//  SERVE_FRAMES=2, no buttons -> PLAY on 2nd tick; ball (318,238) after 1st PLAY tick.
//  ball y=2, dy=-1 -> next tick y=0, dy=+1; following tick y=2.
//  l_up held 200 frames -> left paddle y=0, stays 0; l_up&l_dn held -> y unchanged.
//  left paddle y=200, ball (26,220), dx=-1 -> x=24, dx=+1, scores unchanged; paddle y=0 -> score_r=1, SERVE.
//  WIN_SCORE=1, miss -> game_over=1, ball not drawn; start -> scores 0, SERVE; PONG_AI_EN -> right never misses.

Source files
------------

// File: rtl/pong_game_renderer_if.sv
// Pixel-stream interface between the VGA counter generator and the Pong renderer.
// Transfer rule: there is no valid/ready pair; the counters are a free-running
// stream, one pixel per clock, and every clock's counter_x/counter_y/in_display_area
// is consumed. Colour for that pixel appears one clock later on vga_r/g/b.
// The *Dbg signals expose the game state for observation only
// (stateDbg: 0 = SERVE, 1 = PLAY, 2 = GAMEOVER).
interface pong_game_renderer_if;
  logic [9:0] counter_x;
  logic [8:0] counter_y;
  logic       in_display_area;
  logic       l_up;
  logic       l_dn;
  logic       r_up;
  logic       r_dn;
  logic       start;
  logic       vga_r;
  logic       vga_g;
  logic       vga_b;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic [1:0] stateDbg;
  logic [9:0] ballXDbg;
  logic [8:0] ballYDbg;
  logic [8:0] padLDbg;
  logic [8:0] padRDbg;

  // Counter/button source side (sync generator plus board buttons).
  modport master (
    output counter_x, counter_y, in_display_area, l_up, l_dn, r_up, r_dn, start,
    input  vga_r, vga_g, vga_b, score_l, score_r, game_over,
    input  stateDbg, ballXDbg, ballYDbg, padLDbg, padRDbg
  );

  // Renderer side.
  modport slave (
    input  counter_x, counter_y, in_display_area, l_up, l_dn, r_up, r_dn, start,
    output vga_r, vga_g, vga_b, score_l, score_r, game_over,
    output stateDbg, ballXDbg, ballYDbg, padLDbg, padRDbg
  );
endinterface

// File: rtl/pong_game_renderer.sv
// pong_game_renderer: two-player Pong driven by the VGA pixel counters.
// Game state advances once per frame (counter_x==0, counter_y==480); colour is
// registered from the current counters with one clock of latency.
// Ball and paddle positions are top-left corners; ball is 8x8, paddles 8 wide.
// Optional feature: define PONG_AI_EN to make the right paddle follow the ball
// (r_up/r_dn are then ignored).
module pong_game_renderer #(
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input logic                 clk,
  input logic                 rst_n,
  pong_game_renderer_if.slave bus
);

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    PLAY     = 2'd1,
    GAMEOVER = 2'd2
  } state_t;

  localparam logic signed [10:0] PAD_MAX    = 11'(480 - PADDLE_H);
  localparam logic [8:0]         PAD_INIT   = 9'((480 - PADDLE_H) / 2);
  localparam logic signed [10:0] PAD_STEP   = 11'(PADDLE_SPEED);
  localparam logic signed [10:0] BALL_STEP  = 11'(BALL_SPEED);
  localparam logic [10:0]        PAD_SPAN   = 11'(PADDLE_H - 1);
  localparam logic [9:0]         BALL_X0    = 10'd316;
  localparam logic [8:0]         BALL_Y0    = 9'd236;
  localparam logic [15:0]        SERVE_LOAD = 16'(SERVE_FRAMES);
  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

  state_t      state;
  logic [15:0] serveCnt;
  logic [9:0]  ballX;
  logic [8:0]  ballY;
  logic        dxPos;
  logic        dyPos;
  logic [3:0]  scoreL;
  logic [3:0]  scoreR;
  logic        gameOver;
  logic [8:0]  padL;
  logic [8:0]  padR;
  logic [2:0]  rgb;

  logic               frameTick;
  logic signed [10:0] nxRaw;
  logic signed [10:0] nyRaw;
  logic [9:0]         nxNext;
  logic [8:0]         nyNext;
  logic               dyNext;
  logic               ovL;
  logic               ovR;
  logic               hitL;
  logic               hitR;
  logic               missL;
  logic               missR;
  logic [3:0]         scoreLInc;
  logic [3:0]         scoreRInc;
  logic               rUpEff;
  logic               rDnEff;
  logic [10:0]        cx;
  logic [10:0]        cy;
  logic               ballOn;
  logic               padOn;
  logic               netOn;

  assign frameTick = (bus.counter_x == 10'd0) && (bus.counter_y == 9'd480);

  // One paddle step with clamping; signed so a step above the top clamps instead of wrapping.
  function automatic logic [8:0] movePad(input logic [8:0] y, input logic up, input logic dn);
    logic signed [10:0] t;
    t = signed'({2'b00, y});
    if (up && !dn)      t = t - PAD_STEP;
    else if (dn && !up) t = t + PAD_STEP;
    if (t < 11'sd0)        t = 11'sd0;
    else if (t > PAD_MAX)  t = PAD_MAX;
    return t[8:0];
  endfunction

  // Candidate ball move for this frame plus wall, paddle and miss decisions on the new position.
  always_comb begin
    nxRaw  = signed'({1'b0, ballX}) + (dxPos ? BALL_STEP : -BALL_STEP);
    nyRaw  = signed'({2'b00, ballY}) + (dyPos ? BALL_STEP : -BALL_STEP);
    nyNext = nyRaw[8:0];
    dyNext = dyPos;
    if (nyRaw <= 11'sd0) begin
      nyNext = 9'd0;
      dyNext = 1'b1;
    end else if (nyRaw >= 11'sd472) begin
      nyNext = 9'd472;
      dyNext = 1'b0;
    end
    // Overlap uses the paddle positions held before this frame's paddle step.
    ovL = ({2'b00, nyNext} + 11'd7 >= {2'b00, padL}) && ({2'b00, nyNext} <= {2'b00, padL} + PAD_SPAN);
    ovR = ({2'b00, nyNext} + 11'd7 >= {2'b00, padR}) && ({2'b00, nyNext} <= {2'b00, padR} + PAD_SPAN);
    hitL  = !dxPos && (nxRaw <= 11'sd24) && ovL;
    hitR  = dxPos && (nxRaw >= 11'sd608) && ovR;
    missL = !dxPos && (nxRaw <= 11'sd0) && !hitL;
    missR = dxPos && (nxRaw >= 11'sd632) && !hitR;
    nxNext = hitL ? 10'd24 : (hitR ? 10'd608 : nxRaw[9:0]);
    scoreLInc = (scoreL == 4'hF) ? 4'hF : scoreL + 4'd1;
    scoreRInc = (scoreR == 4'hF) ? 4'hF : scoreR + 4'd1;
  end

`ifdef PONG_AI_EN
  logic [10:0] ballMid;
  logic [10:0] padMid;

  // Right paddle centre chases the ball centre outside a +-4 pixel dead band.
  always_comb begin
    ballMid = {2'b00, ballY} + 11'd4;
    padMid  = {2'b00, padR} + 11'(PADDLE_H / 2);
    rUpEff  = (ballMid + 11'd4) < padMid;
    rDnEff  = ballMid > (padMid + 11'd4);
  end
`else
  assign rUpEff = bus.r_up;
  assign rDnEff = bus.r_dn;
`endif

  // Game FSM: serve countdown, ball flight and scoring, game over; advances on frame ticks only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SERVE;
      serveCnt <= SERVE_LOAD;
      ballX    <= BALL_X0;
      ballY    <= BALL_Y0;
      dxPos    <= 1'b1;
      dyPos    <= 1'b1;
      scoreL   <= 4'd0;
      scoreR   <= 4'd0;
      gameOver <= 1'b0;
    end else if (frameTick) begin
      case (state)
        SERVE: begin
          ballX <= BALL_X0;
          ballY <= BALL_Y0;
          if (serveCnt <= 16'd1) begin
            serveCnt <= 16'd0;
            state    <= PLAY;
          end else begin
            serveCnt <= serveCnt - 16'd1;
          end
        end
        PLAY: begin
          dyPos <= dyNext;
          if (missL || missR) begin
            ballX    <= BALL_X0;
            ballY    <= BALL_Y0;
            serveCnt <= SERVE_LOAD;
            // Next serve heads toward the player who just conceded.
            dxPos    <= missR;
            if (missL) begin
              scoreR <= scoreRInc;
              if (scoreRInc >= WIN) begin
                state    <= GAMEOVER;
                gameOver <= 1'b1;
              end else begin
                state <= SERVE;
              end
            end else begin
              scoreL <= scoreLInc;
              if (scoreLInc >= WIN) begin
                state    <= GAMEOVER;
                gameOver <= 1'b1;
              end else begin
                state <= SERVE;
              end
            end
          end else begin
            ballX <= nxNext;
            ballY <= nyNext;
            if (hitL)      dxPos <= 1'b1;
            else if (hitR) dxPos <= 1'b0;
          end
        end
        GAMEOVER: begin
          if (bus.start) begin
            scoreL   <= 4'd0;
            scoreR   <= 4'd0;
            gameOver <= 1'b0;
            serveCnt <= SERVE_LOAD;
            ballX    <= BALL_X0;
            ballY    <= BALL_Y0;
            state    <= SERVE;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  // Paddles step once per frame and stay frozen while the game is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      padL <= PAD_INIT;
      padR <= PAD_INIT;
    end else if (frameTick && (state != GAMEOVER)) begin
      padL <= movePad(padL, bus.l_up, bus.l_dn);
      padR <= movePad(padR, rUpEff, rDnEff);
    end
  end

  // Object hit tests for the pixel currently on the counters.
  always_comb begin
    cx     = {1'b0, bus.counter_x};
    cy     = {2'b00, bus.counter_y};
    ballOn = (state != GAMEOVER) &&
             (cx >= {1'b0, ballX}) && (cx <= {1'b0, ballX} + 11'd7) &&
             (cy >= {2'b00, ballY}) && (cy <= {2'b00, ballY} + 11'd7);
    padOn  = ((cx >= 11'd16) && (cx <= 11'd23) &&
              (cy >= {2'b00, padL}) && (cy <= {2'b00, padL} + PAD_SPAN)) ||
             ((cx >= 11'd616) && (cx <= 11'd623) &&
              (cy >= {2'b00, padR}) && (cy <= {2'b00, padR} + PAD_SPAN));
    netOn  = ((bus.counter_x == 10'd319) || (bus.counter_x == 10'd320)) && !bus.counter_y[4];
  end

  // Registered colour: ball and paddles white, dashed net green, blanking black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rgb <= 3'b000;
    else if (!bus.in_display_area) rgb <= 3'b000;
    else if (ballOn || padOn)      rgb <= 3'b111;
    else if (netOn)                rgb <= 3'b010;
    else                           rgb <= 3'b000;
  end

  assign bus.vga_r     = rgb[2];
  assign bus.vga_g     = rgb[1];
  assign bus.vga_b     = rgb[0];
  assign bus.score_l   = scoreL;
  assign bus.score_r   = scoreR;
  assign bus.game_over = gameOver;
  assign bus.stateDbg  = state;
  assign bus.ballXDbg  = ballX;
  assign bus.ballYDbg  = ballY;
  assign bus.padLDbg   = padL;
  assign bus.padRDbg   = padR;

endmodule
